// File: rtl/midi_packet_tx.sv
// Serial MIDI transmitter: queues USB-MIDI event packets in a small FIFO and
// shifts the MIDI bytes selected by each packet's CIN out as 8N1 frames.
module midi_packet_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 31_250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        n_rst_in,
  input  logic [31:0] packet_in,
  input  logic        packet_valid_in,
  output logic        packet_ready_out,
  output logic        txd_out,
  output logic        busy_out,
  output logic        error_out
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("midi_packet_tx: CLK_HZ/BAUD must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("midi_packet_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  // Reserved CINs map to zero bytes.
  function automatic logic [1:0] cin_bytes(input logic [3:0] cin);
    case (cin)
      4'h5, 4'hF:             return 2'd1;
      4'h2, 4'h6, 4'hC, 4'hD: return 2'd2;
      4'h0, 4'h1:             return 2'd0;
      default:                return 2'd3;
    endcase
  endfunction

  logic [27:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic [27:0]   head;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [1:0]    bytes_left;
  logic [1:0]    head_bytes;
  logic          bit_end;
  logic [7:0]    shift;
  logic [7:0]    byte1;
  logic [7:0]    byte2;

  logic          unused_cable;
  assign unused_cable = ^packet_in[31:28];

  assign push       = packet_valid_in && packet_ready_out;
  assign pop        = (state == LOAD);
  assign head       = mem[rd_ptr];
  assign head_bytes = cin_bytes(head[27:24]);
  assign bit_end    = (timer == TW'(CLKS_PER_BIT - 1));
  assign busy_out   = (count != '0) || (state != IDLE);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= packet_in[27:0];
  end

  // Ready is registered from the next occupancy, so a full FIFO refuses
  // a push even in a cycle that also pops.
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      packet_ready_out <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count            <= count_next;
      packet_ready_out <= (count_next != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      bytes_left <= '0;
      txd_out    <= 1'b1;
      error_out  <= 1'b0;
    end else begin
      error_out <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (count != '0) state <= LOAD;
        end
        LOAD: begin
          timer <= '0;
          if (head_bytes == 2'd0) begin
            error_out <= 1'b1;
            state     <= IDLE;
          end else begin
            bytes_left <= head_bytes;
            txd_out    <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_cnt <= '0;
            txd_out <= shift[0];
            state   <= DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_cnt == 3'd7) begin
              txd_out <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              txd_out <= shift[1];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            timer      <= '0;
            bytes_left <= bytes_left - 2'd1;
            if (bytes_left != 2'd1) begin
              txd_out <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          timer   <= '0;
          txd_out <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Byte datapath: loaded from the FIFO head, shifted per data bit, and
  // advanced to the next packet byte at the end of each stop bit.
  always_ff @(posedge clk_in) begin
    if (state == LOAD) begin
      shift <= head[23:16];
      byte1 <= head[15:8];
      byte2 <= head[7:0];
    end else if ((state == DATA) && bit_end) begin
      shift <= shift >> 1;
    end else if ((state == STOP) && bit_end) begin
      shift <= byte1;
      byte1 <= byte2;
    end
  end

endmodule

// File: tb/tb_midi_packet_tx.sv
// Bench for midi_packet_tx at CLKS_PER_BIT=16: a line monitor decodes frames
// into a queue that is scored against bytes expected from each accepted packet.
module tb_midi_packet_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pkt = '0;
  logic        vld = 1'b0;
  logic        ready;
  logic        txd;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic [8:0] got_q[$];
  int         rd = 0;

  midi_packet_tx #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk_in          (clk),
    .n_rst_in        (rst_n),
    .packet_in       (pkt),
    .packet_valid_in (vld),
    .packet_ready_out(ready),
    .txd_out         (txd),
    .busy_out        (busy),
    .error_out       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Line monitor: samples each bit at its middle, pushes {frame_ok, byte}.
  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;
  logic       mon_ok = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act <= 1'b0;
    end else if (!mon_act) begin
      if (txd === 1'b0) begin
        mon_act <= 1'b1;
        mon_cnt <= 0;
        mon_ok  <= 1'b1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == 7) begin
        if (txd !== 1'b0) mon_ok <= 1'b0;
      end else if (mon_cnt == 151) begin
        got_q.push_back({mon_ok && (txd === 1'b1), mon_byte});
        mon_act <= 1'b0;
      end else if ((mon_cnt % 16) == 7) begin
        mon_byte <= {txd, mon_byte[7:1]};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [3:0] cin);
    case (cin)
      4'h5, 4'hF:             return 1;
      4'h2, 4'h6, 4'hC, 4'hD: return 2;
      4'h0, 4'h1:             return 0;
      default:                return 3;
    endcase
  endfunction

  task automatic expect_pkt(input logic [31:0] p);
    int n;
    n = nbytes(p[27:24]);
    if (n >= 1) exp_q.push_back(p[23:16]);
    if (n >= 2) exp_q.push_back(p[15:8]);
    if (n >= 3) exp_q.push_back(p[7:0]);
  endtask

  task automatic push(input logic [31:0] p, output logic acc);
    pkt = p;
    vld = 1'b1;
    acc = ready;
    @(posedge clk);
    #1;
    vld = 1'b0;
    if (acc) expect_pkt(p);
  endtask

  task automatic score(input string name, input bit final_chk);
    logic [8:0]  g;
    logic [31:0] e;
    while (rd < got_q.size()) begin
      g = got_q[rd];
      rd++;
      check({name, " framing"}, {31'd0, g[8]}, 32'd1);
      if (exp_q.size() > 0) e = {24'd0, exp_q.pop_front()};
      else e = 32'hFFFF_FFFF;
      check({name, " byte"}, {24'd0, g[7:0]}, e);
    end
    if (final_chk) check({name, " missing bytes"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while ((busy !== 1'b0) && (n < limit)) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_len(input string name, input logic [31:0] p, input int cycles);
    logic acc;
    push(p, acc);
    check({name, " accepted"}, {31'd0, acc}, 32'd1);
    tick(cycles + 1);
    check({name, " busy last cycle"}, {31'd0, busy}, 32'd1);
    tick(1);
    check({name, " busy after"}, {31'd0, busy}, 32'd0);
    check({name, " txd idle"}, {31'd0, txd}, 32'd1);
    score(name, 1'b1);
  endtask

  initial begin
    logic        acc;
    int          lows;
    int          n_acc;
    int          idx;
    logic        saw_full;
    logic [31:0] pk [6];

    pk[0] = 32'h05A10000; pk[1] = 32'h05B20000; pk[2] = 32'h05C30000;
    pk[3] = 32'h05D40000; pk[4] = 32'h05E50000; pk[5] = 32'h05F70000;

    // Reset
    rst_n = 1'b0;
    tick(3);
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset error", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("release txd", {31'd0, txd}, 32'd1);
    check("release busy", {31'd0, busy}, 32'd0);

    // Note On: latency, back-to-back bytes, 480-cycle line time
    push(32'h09903C64, acc);
    check("noteon accepted", {31'd0, acc}, 32'd1);
    check("noteon busy", {31'd0, busy}, 32'd1);
    check("noteon txd at E", {31'd0, txd}, 32'd1);
    tick(1);
    check("noteon txd at E+1", {31'd0, txd}, 32'd1);
    tick(1);
    check("noteon txd at E+2", {31'd0, txd}, 32'd0);
    tick(159);
    check("noteon stop0", {31'd0, txd}, 32'd1);
    tick(1);
    check("noteon start1 no gap", {31'd0, txd}, 32'd0);
    tick(160);
    check("noteon start2 no gap", {31'd0, txd}, 32'd0);
    tick(159);
    check("noteon busy end-1", {31'd0, busy}, 32'd1);
    tick(1);
    check("noteon busy end", {31'd0, busy}, 32'd0);
    score("noteon", 1'b1);

    // Byte counts and cable nibble
    tick(3);
    run_len("cin F", 32'h0FF80000, 160);
    tick(3);
    run_len("cin C", 32'h0CC50000, 320);
    tick(3);
    run_len("cable F cin C", 32'hFCC50000, 320);

    // Reserved CIN
    tick(3);
    push(32'h01123456, acc);
    check("reserved accepted", {31'd0, acc}, 32'd1);
    check("reserved err E", {31'd0, err}, 32'd0);
    tick(1);
    check("reserved err E+1", {31'd0, err}, 32'd0);
    tick(1);
    check("reserved err E+2", {31'd0, err}, 32'd1);
    check("reserved busy E+2", {31'd0, busy}, 32'd0);
    tick(1);
    check("reserved err E+3", {31'd0, err}, 32'd0);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (txd !== 1'b1) lows++;
      tick(1);
    end
    check("reserved txd high", lows, 32'd0);
    score("reserved", 1'b1);
    run_len("after reserved", 32'h05F60000, 160);

    // FIFO full: hold valid across the first frame
    tick(3);
    n_acc = 0;
    idx = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 12; c++) begin
      pkt = pk[idx];
      vld = 1'b1;
      acc = ready;
      if (!ready) saw_full = 1'b1;
      @(posedge clk);
      #1;
      if (acc) begin
        expect_pkt(pk[idx]);
        n_acc++;
        if (idx < 5) idx++;
      end
    end
    vld = 1'b0;
    check("full accepted 4 or 5", {31'd0, (n_acc == 4) || (n_acc == 5)}, 32'd1);
    check("full ready low", {31'd0, ready}, 32'd0);
    check("full ready dropped", {31'd0, saw_full}, 32'd1);
    wait_idle("full drain", 3000);
    check("full ready restored", {31'd0, ready}, 32'd1);
    score("full", 1'b1);

    // Reset in DATA of byte 1 with two packets queued
    tick(3);
    push(32'h09903C64, acc);
    push(32'h0CC50000, acc);
    push(32'h0FF80000, acc);
    tick(198);
    check("midrst busy before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst txd", {31'd0, txd}, 32'd1);
    check("midrst ready", {31'd0, ready}, 32'd1);
    check("midrst busy", {31'd0, busy}, 32'd0);
    score("midrst byte0", 1'b0);
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      if (txd !== 1'b1) lows++;
      tick(1);
    end
    check("post reset txd high", lows, 32'd0);
    check("post reset busy", {31'd0, busy}, 32'd0);
    score("post reset", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_packet_tx.md
# midi_packet_tx

Serial MIDI transmitter for USB-MIDI event packets. It accepts 32-bit USB-MIDI event packets, the same layout the USB controller emits on its MIDI output, and buffers them in a small FIFO. Each packet's Code Index Number (CIN) sets its MIDI byte count, and those bytes are shifted out as standard 8N1 serial MIDI on a single TX line. It is the outbound counterpart of the USB-MIDI receive path and drives a DIN/UART MIDI output pin from the top level.

## Interface
- CLK_HZ, 100_000_000, frequency of clk_in in Hz.
- BAUD, 31_250, serial bit rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer division; elaboration error if < 2.
- FIFO_DEPTH, 4, packet FIFO depth. Must be a power of two, ≥ 2.
- clk_in  input  1  system clock.
- n_rst_in  input  1  asynchronous, active-low reset.
- packet_in  input  32  USB-MIDI event packet:
  - [31:28] cable number, ignored.
  - [27:24] CIN.
  - [23:16] MIDI byte 0, [15:8] MIDI byte 1, [7:0] MIDI byte 2.
- packet_valid_in  input  1  packet_in is valid this cycle.
- packet_ready_out  output  1  FIFO can accept a packet (registered; equals !full).
- txd_out  output  1  serial MIDI line; idle high.
- busy_out  output  1  high while the FIFO is non-empty or the serializer is not IDLE.
- error_out  output  1  one-cycle pulse when a packet with a reserved CIN is dropped.

## Operation
- Handshake: a packet is written on any rising edge where packet_valid_in && packet_ready_out. Data while ready is low is ignored, not queued.
- FIFO: FIFO_DEPTH entries with wrapping read/write pointers and an occupancy count. Push and pop in the same cycle leaves the count unchanged. When full, packet_ready_out is low, so a push in the same cycle as a pop is still refused.
- CIN to MIDI byte count:
  - 0x5, 0xF → 1 byte.
  - 0x2, 0x6, 0xC, 0xD → 2 bytes.
  - 0x3, 0x4, 0x7–0xB, 0xE → 3 bytes.
  - 0x0, 0x1 (reserved) → packet dropped, error_out pulses.
- Bytes are sent in order byte 0, byte 1, byte 2, truncated to the count. No running-status compression.
- Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: go to LOAD when the FIFO is non-empty.
  - LOAD: pop the FIFO head and latch the packet. Decode the CIN to bytes_left. If reserved: pulse error_out, return to IDLE. Else: go to START with byte 0 loaded into the shift register.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive shift[0] for each bit; shift after every bit period. After 8 bits, go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. Then decrement bytes_left. If nonzero: load the next byte and go to START. Else go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and resets at every state entry. Width is clog2(CLKS_PER_BIT).
- txd_out is registered.

## Timing
- Reset values (asynchronous, taking effect immediately when n_rst_in falls):
  - txd_out=1, packet_ready_out=1, busy_out=0, error_out=0.
  - FSM in IDLE, FIFO empty.
- Reset mid-frame aborts the frame and drops any queued packets. txd_out returns high immediately.
- Latency with an empty FIFO and IDLE FSM, from accepting edge E:
  - FIFO non-empty after E.
  - LOAD at E+1.
  - txd_out falls at E+2.
- Bytes within a packet are back-to-back: a start bit follows the stop bit with no idle gap.
- Between packets, the line idles high for 2 cycles (IDLE→LOAD→START).
- A 3-byte packet occupies 30·CLKS_PER_BIT cycles of line time.
- error_out is high for exactly the one cycle after the LOAD that dropped the packet. The FSM is back in IDLE that same cycle.
- busy_out falls on the cycle the FSM enters IDLE with the FIFO empty.

## Test plan
All scenarios use CLK_HZ=16, BAUD=1 (CLKS_PER_BIT=16).
- Reset: hold n_rst_in low, then release → txd_out=1, packet_ready_out=1, busy_out=0, error_out=0.
- Note On:
  - Stimulus: push 0x09903C64.
  - Required: txd_out falls 2 cycles after acceptance.
  - Required: bytes 0x90, 0x3C, 0x64 decoded LSB-first at mid-bit.
  - Required: 480 cycles of frames, no inter-byte gap, then busy_out=0.
- Byte counts:
  - Push 0x0FF80000 → a single 0xF8 frame (160 cycles).
  - Push 0x0CC50000 → 0xC5, 0x00 (320 cycles).
  - Cable nibble 0xF in 0xFCC50000 → identical output.
- Reserved CIN:
  - Push 0x01123456 → error_out pulses once, txd_out stays high.
  - Next packet 0x05F60000 is still sent as 0xF6.
- FIFO full:
  - Hold packet_valid_in high with 6 distinct packets during the first frame.
  - Required: 4 (in-flight packet + 3 queued) or 5 accepted, consistent with the FIFO count.
  - Required: ready drops while full; refused packets never appear on txd_out.
  - Required: order preserved.
- Reset mid-operation: assert n_rst_in in the DATA state of byte 1 with 2 packets queued → txd_out=1 at once. After release, with no further input, txd_out stays high and busy_out=0.
